// File: rtl/prei_sched.sv
// prei_sched: raster-order CTU scheduler for pre-intra with a two-bank mode/QP ping-pong.
// Optional run-phase watchdog enabled by defining PREI_SCHED_WDT_EN.
module prei_sched #(
  parameter int unsigned X_W        = 7,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned WDT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           frame_start_i,
  input  logic [X_W-1:0] ctu_x_last_i,
  input  logic [Y_W-1:0] ctu_y_last_i,
  input  logic           src_rdy_i,
  output logic           src_ack_o,
  output logic           prei_start_o,
  input  logic           prei_done_i,
  output logic [X_W-1:0] rc_ctu_x_o,
  output logic [Y_W-1:0] rc_ctu_y_o,
  output logic           wr_bank_o,
  output logic           out_valid_o,
  output logic           out_bank_o,
  output logic [X_W-1:0] out_ctu_x_o,
  output logic [Y_W-1:0] out_ctu_y_o,
  input  logic           out_release_i,
  output logic           frame_done_o,
  output logic           busy_o,
  output logic           wdt_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d, x_last_q, x_last_d;
  logic [Y_W-1:0] y_q, y_d, y_last_q, y_last_d;
  logic [1:0]     full_q, full_d;
  logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [X_W-1:0] bank_x_q [2];
  logic [X_W-1:0] bank_x_d [2];
  logic [Y_W-1:0] bank_y_q [2];
  logic [Y_W-1:0] bank_y_d [2];
  logic           busy_q, busy_d;
  logic           launch, finish, done_eff;

`ifdef PREI_SCHED_WDT_EN
  localparam int unsigned WDT_W = 16;

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_err_q, wdt_err_d, wdt_hit;

  // A stalled pre-intra is forced to completion so the frame keeps moving.
  assign wdt_hit  = (state_q == S_RUN) && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
  assign done_eff = prei_done_i | wdt_hit;

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = wdt_err_q | (wdt_hit & ~prei_done_i);
    if (launch) begin
      wdt_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
    end
  end

  assign wdt_err_o = wdt_err_q;
`else
  logic unused_wdt;

  assign unused_wdt = ^WDT_CYCLES;
  assign done_eff   = prei_done_i;
  assign wdt_err_o  = 1'b0;
`endif

  // Next-state, bank bookkeeping and handshake pulses.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    bank_x_d = bank_x_q;
    bank_y_d = bank_y_q;
    busy_d   = busy_q;
    launch   = 1'b0;
    finish   = 1'b0;

    // Release and set always hit different banks: a bank is only set when empty.
    if (out_release_i && full_q[rd_ptr_q]) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          x_last_d = ctu_x_last_i;
          y_last_d = ctu_y_last_i;
          x_d      = '0;
          y_d      = '0;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (src_rdy_i && !full_q[wr_ptr_q] && !rstn) begin
          launch  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (done_eff) begin
          full_d[wr_ptr_q]   = 1'b1;
          bank_x_d[wr_ptr_q] = x_q;
          bank_y_d[wr_ptr_q] = y_q;
          wr_ptr_d           = ~wr_ptr_q;
          if (x_q == x_last_q && y_q == y_last_q) begin
            state_d = S_DRAIN;
          end else begin
            if (x_q == x_last_q) begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
            state_d = S_WAIT;
          end
        end
      end
      S_DRAIN: begin
        if (full_q == 2'b00 && !rstn) begin
          finish  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x_last_q    <= '0;
      y_last_q    <= '0;
      full_q      <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      bank_x_q[0] <= '0;
      bank_x_q[1] <= '0;
      bank_y_q[0] <= '0;
      bank_y_q[1] <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_last_q    <= x_last_d;
      y_last_q    <= y_last_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bank_x_q    <= bank_x_d;
      bank_y_q    <= bank_y_d;
      busy_q      <= busy_d;
    end
  end

  assign prei_start_o = launch;
  assign src_ack_o    = launch;
  assign frame_done_o = finish;
  assign busy_o       = busy_q;
  assign rc_ctu_x_o   = x_q;
  assign rc_ctu_y_o   = y_q;
  assign wr_bank_o    = wr_ptr_q;
  assign out_bank_o   = rd_ptr_q;
  assign out_valid_o  = full_q[rd_ptr_q];
  assign out_ctu_x_o  = bank_x_q[rd_ptr_q];
  assign out_ctu_y_o  = bank_y_q[rd_ptr_q];

endmodule

// File: doc/prei_sched.md
Name: prei_sched

Overview:
- Per-CTU scheduler for the pre-intra stage, i.e. mode decision followed by LCU rate control.
- Walks the CTUs of a frame in raster order and waits until each CTU's original pixels are loaded.
- Pulses the pre-intra start and waits for its done.
- Hands results to the downstream encoder through a two-bank ping-pong of mode/QP storage, so pre-intra can run one CTU ahead of the consumer.

Parameters:
X_W, 7, width of CTU x coordinate
Y_W, 7, width of CTU y coordinate
WDT_CYCLES, 65535, watchdog limit in cycles (used only with PREI_SCHED_WDT_EN)

Ports:
clk  in  1  clock; all logic is rising-edge
rstn  in  1  synchronous, active-high reset (1 = reset)
frame_start_i  in  1  one-cycle pulse that starts a frame; ignored unless idle
ctu_x_last_i  in  X_W  last CTU column index of the frame, sampled at frame_start_i
ctu_y_last_i  in  Y_W  last CTU row index of the frame, sampled at frame_start_i
src_rdy_i  in  1  original pixels of the current CTU are loaded
src_ack_o  out  1  one-cycle pulse; CTU pixels are consumed, so the loader may proceed
prei_start_o  out  1  one-cycle start pulse to pre-intra
prei_done_i  in  1  one-cycle done pulse from pre-intra
rc_ctu_x_o  out  X_W  x of the CTU under pre-intra
rc_ctu_y_o  out  Y_W  y of the CTU under pre-intra
wr_bank_o  out  1  bank that pre-intra writes
out_valid_o  out  1  a completed bank is available downstream
out_bank_o  out  1  bank index offered downstream
out_ctu_x_o  out  X_W  x of the offered CTU
out_ctu_y_o  out  Y_W  y of the offered CTU
out_release_i  in  1  downstream is finished with the offered bank
frame_done_o  out  1  one-cycle pulse after the last CTU is released
busy_o  out  1  high from frame start until frame_done_o
wdt_err_o  out  1  watchdog error, sticky until reset (held 0 without the macro)

Behaviour:
- Reset values: all outputs 0; coordinates 0; bank occupancy {0,0}; write pointer and read pointer 0; FSM in IDLE.
- Bank tracking:
  - full[1:0] marks a bank as full.
  - wr_ptr is the next bank to fill; wr_bank_o = wr_ptr.
  - rd_ptr is the bank being offered; out_bank_o = rd_ptr.
  - out_valid_o = full[rd_ptr].
- FSM states:
  - IDLE: on frame_start_i, latch the last-x/last-y limits, set x = y = 0, busy_o = 1, go to WAIT.
  - WAIT: when src_rdy_i = 1 and full[wr_ptr] = 0, drive prei_start_o = 1 and src_ack_o = 1 for one cycle, go to RUN. src_ack_o has zero latency from that cycle. Otherwise stay in WAIT.
  - RUN: on prei_done_i:
    - set full[wr_ptr];
    - store the CTU x/y in that bank's coordinate register;
    - toggle wr_ptr.
    - If x == last x and y == last y, go to DRAIN.
    - Otherwise advance raster order (x + 1; on x == last x, x = 0 and y + 1) and go to WAIT.
  - DRAIN: when full == {0,0}, pulse frame_done_o, clear busy_o, go to IDLE.
- rc_ctu_x_o / rc_ctu_y_o hold the current CTU from WAIT through RUN. Rate control samples them at prei_done_i.
- Release: out_release_i while out_valid_o = 1 clears full[rd_ptr] and toggles rd_ptr. Release while out_valid_o = 0 is ignored.
- Same-cycle set and clear:
  - prei_done_i and out_release_i on different banks: both take effect.
  - On the same bank: impossible by construction (a bank can only be set when empty).
- Minimum start spacing: a release in cycle N frees the bank, so a WAIT start is possible in cycle N+1 (registered full).
- A 1x1 frame (last x = 0, last y = 0) runs one CTU and then goes to DRAIN.
- frame_start_i outside IDLE is ignored.
- prei_done_i outside RUN is ignored.
- Reset mid-frame clears everything to reset values on the next edge; no pulses are emitted.

Optional Feature:
PREI_SCHED_WDT_EN:
- When defined, a 16-bit counter runs in RUN, clearing on entry to RUN.
- If the counter reaches WDT_CYCLES without prei_done_i:
  - wdt_err_o is set (sticky);
  - the FSM forces completion of the CTU as if prei_done_i had arrived, so the frame does not hang.
- When undefined: no counter, wdt_err_o is tied 0, and RUN waits indefinitely.

Test Plan:
- 2x2 frame, src_rdy_i always 1, prei_done_i 10 cycles after each start, immediate release:
  - start sequence (0,0),(1,0),(0,1),(1,1);
  - wr_bank_o alternates 0,1,0,1;
  - frame_done_o 1 cycle after the final release.
- 3x1 frame with out_release_i held 0:
  - two CTUs complete, full = {1,1};
  - third prei_start_o withheld;
  - release bank 0 -> third start in the next cycle, on bank 0.
- Same-cycle prei_done_i (bank 1) and out_release_i (bank 0) -> full = {1,0}, rd_ptr = 1, out_ctu matches the bank-1 coordinates.
- 1x1 frame; frame_start_i re-pulsed during RUN -> ignored; exactly one start and one frame_done_o.
- rstn = 1 during RUN of CTU (1,0) -> all outputs 0 next cycle; a new frame_start_i restarts at (0,0) on bank 0.
- With PREI_SCHED_WDT_EN and WDT_CYCLES = 20, prei_done_i never asserted -> wdt_err_o = 1 at cycle 20 of RUN, CTU marked full, scheduler advances.
